// File: rtl/ball_motion_pkg.sv
// rtl/ball_motion_pkg.sv - shared playfield constants and FSM state type for the pong ball
package pong_pkg;

  localparam int SCREEN_W_DEF      = 640;
  localparam int SCREEN_H_DEF      = 480;
  localparam int BALL_SIZE_DEF     = 8;
  localparam int PADDLE_H_DEF      = 64;
  localparam int PADDLE_L_FACE_DEF = 24;
  localparam int PADDLE_R_FACE_DEF = 616;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCORED
  } state_t;

  // Top-left coordinate that centres an object of `size` within `extent`.
  function automatic int centre(input int extent, input int size);
    return (extent - size) / 2;
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// rtl/ball_motion_if.sv - control inputs and ball state outputs of the ball mover
interface ball_motion_if;

  logic game_on;
  logic serve;
  int   ticks_per_px;
  int   left_paddle_y;
  int   right_paddle_y;
  int   ball_x;
  int   ball_y;
  logic dir_right;
  logic dir_down;
  logic score_left;
  logic score_right;
  logic in_play;

  modport master (
    output game_on, serve, ticks_per_px, left_paddle_y, right_paddle_y,
    input  ball_x, ball_y, dir_right, dir_down, score_left, score_right, in_play
  );

  modport slave (
    input  game_on, serve, ticks_per_px, left_paddle_y, right_paddle_y,
    output ball_x, ball_y, dir_right, dir_down, score_left, score_right, in_play
  );

endinterface

// File: rtl/ball_motion_step_divider.sv
// rtl/ball_motion_step_divider.sv - clock divider producing one-pixel step strobes
module step_divider (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  int   ticks_per_px,
  output logic step
);

  int r_cnt;
  int w_term;

  // Non-positive rates collapse to one step per clock; >= lets a lowered rate fire at once.
  assign w_term = (ticks_per_px > 1) ? ticks_per_px - 1 : 0;
  assign step   = enable && (r_cnt >= w_term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 0;
    end else if (enable) begin
      r_cnt <= step ? 0 : r_cnt + 1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - pong ball FSM: serve, wall/paddle bounces, miss detection
module ball_motion
  import pong_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int BALL_SIZE     = BALL_SIZE_DEF,
  parameter int PADDLE_H      = PADDLE_H_DEF,
  parameter int PADDLE_L_FACE = PADDLE_L_FACE_DEF,
  parameter int PADDLE_R_FACE = PADDLE_R_FACE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  ball_motion_if.slave  bus
);

  localparam int X_CENTRE = centre(SCREEN_W, BALL_SIZE);
  localparam int Y_CENTRE = centre(SCREEN_H, BALL_SIZE);

  state_t r_state;
  int     r_ball_x;
  int     r_ball_y;
  logic   r_dir_right;
  logic   r_dir_down;
  logic   r_score_left;
  logic   r_score_right;
  logic   r_in_play;
  logic   r_serve_right;

  logic   w_div_en;
  logic   w_step;
  logic   w_hit_l;
  logic   w_hit_r;

  assign w_div_en = bus.game_on && (r_state == ST_PLAY);

  step_divider u_step_divider (
    .clk          (clk),
    .reset        (reset),
    .enable       (w_div_en),
    .ticks_per_px (bus.ticks_per_px),
    .step         (w_step)
  );

  assign w_hit_l = (r_ball_y + BALL_SIZE > bus.left_paddle_y) &&
                   (r_ball_y < bus.left_paddle_y + PADDLE_H);
  assign w_hit_r = (r_ball_y + BALL_SIZE > bus.right_paddle_y) &&
                   (r_ball_y < bus.right_paddle_y + PADDLE_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ball_x      <= X_CENTRE;
      r_ball_y      <= Y_CENTRE;
      r_dir_right   <= 1'b1;
      r_dir_down    <= 1'b1;
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
      r_in_play     <= 1'b0;
      r_serve_right <= 1'b1;
    end else begin
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
      if (bus.game_on) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.serve) begin
              r_state   <= ST_PLAY;
              r_in_play <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (w_step) begin
              // Vertical and horizontal rules are independent so corners flip both axes.
              if (!r_dir_down) begin
                if (r_ball_y == 0) r_dir_down <= 1'b1;
                else               r_ball_y   <= r_ball_y - 1;
              end else begin
                if (r_ball_y == SCREEN_H - BALL_SIZE) r_dir_down <= 1'b0;
                else                                  r_ball_y   <= r_ball_y + 1;
              end
              if (!r_dir_right) begin
                if (r_ball_x == 0) begin
                  r_score_right <= 1'b1;
                  r_serve_right <= 1'b0;
                  r_state       <= ST_SCORED;
                  r_in_play     <= 1'b0;
                end else if (r_ball_x == PADDLE_L_FACE && w_hit_l) begin
                  r_dir_right <= 1'b1;
                end else begin
                  r_ball_x <= r_ball_x - 1;
                end
              end else begin
                if (r_ball_x == SCREEN_W - BALL_SIZE) begin
                  r_score_left  <= 1'b1;
                  r_serve_right <= 1'b1;
                  r_state       <= ST_SCORED;
                  r_in_play     <= 1'b0;
                end else if (r_ball_x + BALL_SIZE == PADDLE_R_FACE && w_hit_r) begin
                  r_dir_right <= 1'b0;
                end else begin
                  r_ball_x <= r_ball_x + 1;
                end
              end
            end
          end
          ST_SCORED: begin
            r_ball_x    <= X_CENTRE;
            r_ball_y    <= Y_CENTRE;
            r_dir_right <= r_serve_right;
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ball_x      = r_ball_x;
  assign bus.ball_y      = r_ball_y;
  assign bus.dir_right   = r_dir_right;
  assign bus.dir_down    = r_dir_down;
  assign bus.score_left  = r_score_left;
  assign bus.score_right = r_score_right;
  assign bus.in_play     = r_in_play;

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameter SCREEN_W, 640, playfield width in pixels.
REQ-002 SHALL have parameter SCREEN_H, 480, playfield height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, 8, ball edge length in pixels.
REQ-004 SHALL have parameter PADDLE_H, 64, paddle height in pixels.
REQ-005 SHALL have parameter PADDLE_L_FACE, 24, x of the left paddle's right face.
REQ-006 SHALL have parameter PADDLE_R_FACE, 616, x of the right paddle's left face.
REQ-007 SHALL have clk  input  1  single system clock, all state on rising edge.
REQ-008 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have game_on  input  1  high = motion enabled, low = freeze.
REQ-010 SHALL have serve  input  1  level; launches ball from IDLE.
REQ-011 SHALL have ticks_per_px  input  32 (int)  clocks per one-pixel step.
REQ-012 SHALL have left_paddle_y, right_paddle_y  input  32 (int)  paddle top-edge y.
REQ-013 SHALL have ball_x, ball_y  output  32 (int)  ball top-left corner; ball_y feeds the computer player.
REQ-014 SHALL have dir_right, dir_down  output  1  current velocity signs.
REQ-015 SHALL have score_left, score_right  output  1  one-clock pulse when that side scores.
REQ-016 SHALL have in_play  output  1  high while state is PLAY.

Function
REQ-017 SHALL implement states IDLE, PLAY, SCORED.
REQ-018 IDLE: ball held at centre (316,236); serve=1 and game_on=1 -> PLAY next clock.
REQ-019 PLAY: step counter increments each clock while game_on=1; at count = max(ticks_per_px,1)-1 it clears and asserts a one-clock step.
REQ-020 game_on=0 in any state SHALL freeze counter, position, direction and state.
REQ-021 On a step, ball_x and ball_y each move exactly 1 pixel in the direction of dir_right/dir_down unless REQ-022..025 apply to that axis.
REQ-022 Top wall: step with dir_down=0 and ball_y=0 -> dir_down:=1, ball_y unchanged.
REQ-023 Bottom wall: step with dir_down=1 and ball_y=SCREEN_H-BALL_SIZE -> dir_down:=0, ball_y unchanged.
REQ-024 Left paddle hit: step with dir_right=0, ball_x=PADDLE_L_FACE, ball_y+BALL_SIZE>left_paddle_y and ball_y<left_paddle_y+PADDLE_H -> dir_right:=1, ball_x unchanged; right paddle symmetric at ball_x+BALL_SIZE=PADDLE_R_FACE.
REQ-025 Miss: step with dir_right=0 and ball_x=0 -> score_right pulse, state SCORED; dir_right=1 and ball_x=SCREEN_W-BALL_SIZE -> score_left pulse, SCORED.
REQ-026 Wall and paddle conditions on the same step SHALL both apply (corner bounce, both axes flip).
REQ-027 SCORED lasts one clock: ball recentred, counter cleared, dir_right set toward the side that conceded, dir_down unchanged, then IDLE.
REQ-028 Change of ticks_per_px mid-count SHALL take effect at the next comparison; a count already >= new terminal value SHALL step immediately.
REQ-029 All comparisons and arithmetic SHALL be signed 32-bit; no wrap-around of ball coordinates is permitted.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, ball_x=316, ball_y=236, dir_right=1, dir_down=1, counter=0, score pulses=0, in_play=0.
REQ-031 Reset asserted mid-PLAY or mid-SCORED SHALL suppress any pending score pulse.

Structure
REQ-032 Screen/paddle constants and the state enum SHALL live in shared package pong_pkg.
REQ-033 Step counter SHALL be a sub-module step_divider (inputs clk, reset, enable, ticks_per_px; output step).

Verification
REQ-034 Reset, serve=1, ticks_per_px=4 -> in_play=1 next clock, ball_x=317 ball_y=237 after 4 clocks in PLAY.
REQ-035 ball_y=0, dir_down=0, step -> dir_down=1, ball_y stays 0, next step ball_y=1.
REQ-036 left_paddle_y=200, ball (24,230) moving left, step -> dir_right=1, ball_x stays 24.
REQ-037 left_paddle_y=0, ball (0,400) moving left, step -> score_right high exactly 1 clock, ball (316,236), dir_right=0, state IDLE.
REQ-038 game_on=0 for 100 clocks in PLAY -> ball_x, ball_y, counter unchanged; resumes identically.
REQ-039 reset pulsed low asynchronously mid-PLAY (between clocks) -> outputs at reset values immediately, no score pulse.
